// File: rtl/rom_port_arbiter_if.sv
// Purpose : bundles the Fetch/Memory request handshakes and the ROM read port.
// Latency : none, wiring only.
// Backpres: start is a level request held until the matching one-cycle done pulse.
// Ports   : fe_start/fe_addr -> fe_q/fe_done     Fetch requester
//           mem_start/mem_addr -> mem_q/mem_done Memory requester
//           rom_addr -> rom_q                    synchronous ROM, data one clock after address
//           modport master = CPU stages + ROM, modport slave = arbiter
interface rom_port_arbiter_if #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 10
);
   logic                 fe_start;
   logic [ADDR_BITS-1:0] fe_addr;
   logic [WIDTH-1:0]     fe_q;
   logic                 fe_done;
   logic                 mem_start;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [WIDTH-1:0]     mem_q;
   logic                 mem_done;
   logic [ADDR_BITS-1:0] rom_addr;
   logic [WIDTH-1:0]     rom_q;

   modport master (
      output fe_start, fe_addr, mem_start, mem_addr, rom_q,
      input  fe_q, fe_done, mem_q, mem_done, rom_addr
   );

   modport slave (
      input  fe_start, fe_addr, mem_start, mem_addr, rom_q,
      output fe_q, fe_done, mem_q, mem_done, rom_addr
   );
endinterface

// File: rtl/rom_port_arbiter.sv
// Purpose : shares one synchronous ROM read port between Fetch and Memory, alternating on conflict.
// Latency : 3 clocks from start sampled to done pulse; one read per 3 clocks.
// Backpres: requester holds start until done; on conflict the loser waits one full transaction.
// Ports   : i_clk, i_reset (synchronous, active high), bus (rom_port_arbiter_if.slave)
module rom_port_arbiter #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 10
) (
   input  logic                i_clk,
   input  logic                i_reset,
   rom_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_CAPT = 2'd2
   } state_t;

   localparam logic ID_FE  = 1'b0;
   localparam logic ID_MEM = 1'b1;

   state_t               r_state;
   state_t               w_next_state;
   // The requester being served is always the most recent grant, so a single
   // register serves both as the current grant and as the alternation history.
   logic                 r_last_grant;
   logic [ADDR_BITS-1:0] r_rom_addr;
   logic [WIDTH-1:0]     r_fe_q;
   logic [WIDTH-1:0]     r_mem_q;
   logic                 r_fe_done;
   logic                 r_mem_done;

   logic                 w_fe_elig;
   logic                 w_mem_elig;
   logic                 w_any_elig;
   logic                 w_pick;
   logic                 w_load_grant;
   logic                 w_capture;

   // A requester whose done is high this cycle is still holding start from the
   // finished handshake; masking it prevents a duplicate read.
   assign w_fe_elig  = bus.fe_start  & ~r_fe_done;
   assign w_mem_elig = bus.mem_start & ~r_mem_done;
   assign w_any_elig = w_fe_elig | w_mem_elig;
   // Both asking: serve whoever did not go last. Otherwise serve the one asking.
   assign w_pick     = (w_fe_elig & w_mem_elig) ? ~r_last_grant : w_mem_elig;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_any_elig) w_next_state = ST_READ;
         ST_READ: w_next_state = ST_CAPT;
         ST_CAPT: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Output decode: strobes for the datapath registers
   always_comb begin
      w_load_grant = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: w_load_grant = w_any_elig;
         ST_CAPT: w_capture    = 1'b1;
         default: ;
      endcase
   end

   // Datapath: grant/address latch, per-requester data holding registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last_grant <= ID_FE;
         r_rom_addr   <= '0;
         r_fe_q       <= '0;
         r_mem_q      <= '0;
         r_fe_done    <= 1'b0;
         r_mem_done   <= 1'b0;
      end else begin
         r_fe_done  <= 1'b0;
         r_mem_done <= 1'b0;
         if (w_load_grant) begin
            // Address is sampled only here; later changes are ignored.
            r_rom_addr   <= (w_pick == ID_MEM) ? bus.mem_addr : bus.fe_addr;
            r_last_grant <= w_pick;
         end
         if (w_capture) begin
            if (r_last_grant == ID_MEM) begin
               r_mem_q    <= bus.rom_q;
               r_mem_done <= 1'b1;
            end else begin
               r_fe_q     <= bus.rom_q;
               r_fe_done  <= 1'b1;
            end
         end
      end
   end

   assign bus.rom_addr = r_rom_addr;
   assign bus.fe_q     = r_fe_q;
   assign bus.fe_done  = r_fe_done;
   assign bus.mem_q    = r_mem_q;
   assign bus.mem_done = r_mem_done;

endmodule
